// File: rtl/bus_arbiter.sv
// N-master, single-slave bus arbiter with fixed-priority or round-robin grant.
// Routes one transaction at a time to the shared bus and aborts hung ones.
module bus_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ARB_MODE    = 0,
    parameter int TIMEOUT     = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_MASTERS-1:0]          m_rd_req,
    input  logic [NUM_MASTERS-1:0]          m_wr_req,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata,
    input  logic [NUM_MASTERS*DATA_W/8-1:0] m_wrmask,
    output logic [NUM_MASTERS-1:0]          m_rd_valid,
    output logic [NUM_MASTERS-1:0]          m_wr_valid,
    output logic [NUM_MASTERS-1:0]          m_err,
    output logic [DATA_W-1:0]               m_rdata,
    input  logic                            i_bus_rd_valid,
    input  logic                            i_bus_wr_valid,
    input  logic [DATA_W-1:0]               i_bus_data,
    output logic                            o_bus_rd,
    output logic                            o_bus_wr,
    output logic [ADDR_W-1:0]               o_bus_addr,
    output logic [DATA_W/8-1:0]             o_bus_wrmask,
    output logic [DATA_W-1:0]               o_bus_data
);

    localparam int GW    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int MW    = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [GW-1:0]          grant_q, grant_d;
    logic [GW-1:0]          ptr_q, ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   bus_rd_q, bus_rd_d;
    logic                   bus_wr_q, bus_wr_d;
    logic [ADDR_W-1:0]      bus_addr_q, bus_addr_d;
    logic [MW-1:0]          bus_mask_q, bus_mask_d;
    logic [DATA_W-1:0]      bus_data_q, bus_data_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic [NUM_MASTERS-1:0] rd_valid_q, rd_valid_d;
    logic [NUM_MASTERS-1:0] wr_valid_q, wr_valid_d;
    logic [NUM_MASTERS-1:0] err_q, err_d;

    logic [NUM_MASTERS-1:0] req;
    logic                   any_req;
    logic [GW-1:0]          fp_idx;
    logic [GW-1:0]          rr_idx;
    logic                   rr_found;
    logic [GW-1:0]          sel;
    logic [ADDR_W-1:0]      sel_addr;
    logic [DATA_W-1:0]      sel_data;
    logic [MW-1:0]          sel_mask;
    logic                   sel_wr;

    // Pick the candidate grant and mux out its payload
    always_comb begin
        int j;
        logic [GW-1:0] jj;
        j        = 0;
        jj       = '0;
        req      = m_rd_req | m_wr_req;
        any_req  = |req;
        fp_idx   = '0;
        rr_idx   = '0;
        rr_found = 1'b0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (req[GW'(i)]) begin
                fp_idx = GW'(i);
            end
        end
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NUM_MASTERS) begin
                j = j - NUM_MASTERS;
            end
            jj = GW'(j);
            if (!rr_found && req[jj]) begin
                rr_found = 1'b1;
                rr_idx   = jj;
            end
        end
        sel      = (ARB_MODE == 1) ? rr_idx : fp_idx;
        sel_addr = '0;
        sel_data = '0;
        sel_mask = '0;
        sel_wr   = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (sel == GW'(i)) begin
                sel_addr = m_addr[i*ADDR_W +: ADDR_W];
                sel_data = m_wdata[i*DATA_W +: DATA_W];
                sel_mask = m_wrmask[i*MW +: MW];
                sel_wr   = m_wr_req[i];
            end
        end
    end

    // Next-state logic for the IDLE/BUSY/RESP transaction sequencer
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        bus_rd_d   = bus_rd_q;
        bus_wr_d   = bus_wr_q;
        bus_addr_d = bus_addr_q;
        bus_mask_d = bus_mask_q;
        bus_data_d = bus_data_q;
        rdata_d    = rdata_q;
        rd_valid_d = '0;
        wr_valid_d = '0;
        err_d      = '0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d    = sel;
                    if (ARB_MODE == 1) begin
                        ptr_d = sel;
                    end
                    bus_addr_d = sel_addr;
                    bus_data_d = sel_data;
                    bus_mask_d = sel_mask;
                    bus_wr_d   = sel_wr;
                    bus_rd_d   = !sel_wr;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (bus_rd_q && i_bus_rd_valid) begin
                    bus_rd_d            = 1'b0;
                    rdata_d             = i_bus_data;
                    rd_valid_d[grant_q] = 1'b1;
                    state_d             = RESP;
                end else if (bus_wr_q && i_bus_wr_valid) begin
                    bus_wr_d            = 1'b0;
                    wr_valid_d[grant_q] = 1'b1;
                    state_d             = RESP;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    bus_rd_d       = 1'b0;
                    bus_wr_d       = 1'b0;
                    rdata_d        = '0;
                    err_d[grant_q] = 1'b1;
                    state_d        = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ptr_q      <= GW'(NUM_MASTERS - 1);
            cnt_q      <= '0;
            bus_rd_q   <= 1'b0;
            bus_wr_q   <= 1'b0;
            bus_addr_q <= '0;
            bus_mask_q <= '0;
            bus_data_q <= '0;
            rdata_q    <= '0;
            rd_valid_q <= '0;
            wr_valid_q <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            bus_rd_q   <= bus_rd_d;
            bus_wr_q   <= bus_wr_d;
            bus_addr_q <= bus_addr_d;
            bus_mask_q <= bus_mask_d;
            bus_data_q <= bus_data_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_valid_d;
            wr_valid_q <= wr_valid_d;
            err_q      <= err_d;
        end
    end

    assign o_bus_rd     = bus_rd_q;
    assign o_bus_wr     = bus_wr_q;
    assign o_bus_addr   = bus_addr_q;
    assign o_bus_wrmask = bus_mask_q;
    assign o_bus_data   = bus_data_q;
    assign m_rdata      = rdata_q;
    assign m_rd_valid   = rd_valid_q;
    assign m_wr_valid   = wr_valid_q;
    assign m_err        = err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a fixed-priority and a round-robin
// instance share stimulus; both use a 4-cycle timeout.
module tb_bus_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  m_rd_req;
    logic [2:0]  m_wr_req;
    logic [95:0] m_addr;
    logic [95:0] m_wdata;
    logic [11:0] m_wrmask;
    logic        i_bus_rd_valid;
    logic        i_bus_wr_valid;
    logic [31:0] i_bus_data;

    logic [2:0]  fp_rdv, fp_wrv, fp_err;
    logic [31:0] fp_rdata;
    logic        fp_rd, fp_wr;
    logic [31:0] fp_addr, fp_data;
    logic [3:0]  fp_mask;

    logic [2:0]  rr_rdv, rr_wrv, rr_err;
    logic [31:0] rr_rdata;
    logic        rr_rd, rr_wr;
    logic [31:0] rr_addr, rr_data;
    logic [3:0]  rr_mask;

    int total = 0;
    int bad   = 0;

    logic [2:0] v;
    logic [2:0] rr_exp [5];

    bus_arbiter #(.NUM_MASTERS(3), .ADDR_W(32), .DATA_W(32),
                  .ARB_MODE(0), .TIMEOUT(4)) u_fp (
        .clk(clk), .rst(rst),
        .m_rd_req(m_rd_req), .m_wr_req(m_wr_req),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wrmask(m_wrmask),
        .m_rd_valid(fp_rdv), .m_wr_valid(fp_wrv), .m_err(fp_err),
        .m_rdata(fp_rdata),
        .i_bus_rd_valid(i_bus_rd_valid), .i_bus_wr_valid(i_bus_wr_valid),
        .i_bus_data(i_bus_data),
        .o_bus_rd(fp_rd), .o_bus_wr(fp_wr), .o_bus_addr(fp_addr),
        .o_bus_wrmask(fp_mask), .o_bus_data(fp_data)
    );

    bus_arbiter #(.NUM_MASTERS(3), .ADDR_W(32), .DATA_W(32),
                  .ARB_MODE(1), .TIMEOUT(4)) u_rr (
        .clk(clk), .rst(rst),
        .m_rd_req(m_rd_req), .m_wr_req(m_wr_req),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wrmask(m_wrmask),
        .m_rd_valid(rr_rdv), .m_wr_valid(rr_wrv), .m_err(rr_err),
        .m_rdata(rr_rdata),
        .i_bus_rd_valid(i_bus_rd_valid), .i_bus_wr_valid(i_bus_wr_valid),
        .i_bus_data(i_bus_data),
        .o_bus_rd(rr_rd), .o_bus_wr(rr_wr), .o_bus_addr(rr_addr),
        .o_bus_wrmask(rr_mask), .o_bus_data(rr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        m_rd_req       = '0;
        m_wr_req       = '0;
        m_addr         = '0;
        m_wdata        = '0;
        m_wrmask       = '0;
        i_bus_rd_valid = 1'b0;
        i_bus_wr_valid = 1'b0;
        i_bus_data     = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_pulse(input bit use_rr, output logic [2:0] pv);
        pv = '0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (use_rr) pv = rr_rdv | rr_wrv | rr_err;
            else        pv = fp_rdv | fp_wrv | fp_err;
            if (pv != 3'b000) break;
        end
    endtask

    initial begin
        rr_exp[0] = 3'b001;
        rr_exp[1] = 3'b010;
        rr_exp[2] = 3'b100;
        rr_exp[3] = 3'b001;
        rr_exp[4] = 3'b010;

        clr();
        rst = 1'b1;
        tick();
        tick();
        check("rst_fp_rd", fp_rd, 0);
        check("rst_fp_wr", fp_wr, 0);
        check("rst_fp_pulse", {fp_rdv, fp_wrv, fp_err}, 0);
        check("rst_fp_rdata", fp_rdata, 0);
        check("rst_fp_addr", fp_addr, 0);
        check("rst_rr_rd", rr_rd, 0);
        rst = 1'b0;

        // single read from master 1
        m_rd_req = 3'b010;
        m_addr[32 +: 32] = 32'h100;
        tick();
        check("t1_rd", fp_rd, 1);
        check("t1_addr", fp_addr, 32'h100);
        tick();
        check("t1_hold", fp_rd, 1);
        tick();
        check("t1_nopulse", fp_rdv, 0);
        i_bus_rd_valid = 1'b1;
        i_bus_data     = 32'hDEADBEEF;
        tick();
        check("t1_rdv", fp_rdv, 3'b010);
        check("t1_rdata", fp_rdata, 32'hDEADBEEF);
        check("t1_rd_drop", fp_rd, 0);
        i_bus_rd_valid = 1'b0;
        m_rd_req = '0;
        tick();
        check("t1_pulse_end", fp_rdv, 0);
        tick();
        check("t1_idle", fp_rd, 0);

        // fixed priority: masters 0 and 2 both request
        clr();
        do_reset();
        m_rd_req = 3'b101;
        m_addr[0 +: 32]  = 32'hA0;
        m_addr[64 +: 32] = 32'hC0;
        i_bus_rd_valid = 1'b1;
        i_bus_data     = 32'h1234;
        for (int k = 0; k < 3; k++) begin
            wait_pulse(1'b0, v);
            check("t2_fp_grant", v, 3'b001);
        end
        check("t2_fp_addr", fp_addr, 32'hA0);

        // round robin: all three request reads
        clr();
        do_reset();
        m_rd_req = 3'b111;
        i_bus_rd_valid = 1'b1;
        i_bus_data     = 32'hCAFEF00D;
        for (int k = 0; k < 5; k++) begin
            wait_pulse(1'b1, v);
            check("t3_rr_grant", v, rr_exp[k]);
        end
        check("t3_rr_rdata", rr_rdata, 32'hCAFEF00D);

        // write wins over read for the same master
        clr();
        do_reset();
        m_rd_req = 3'b001;
        m_wr_req = 3'b001;
        m_addr[0 +: 32]  = 32'h20;
        m_wdata[0 +: 32] = 32'h11223344;
        m_wrmask[0 +: 4] = 4'b0011;
        tick();
        check("t4_wr", fp_wr, 1);
        check("t4_no_rd", fp_rd, 0);
        check("t4_addr", fp_addr, 32'h20);
        check("t4_data", fp_data, 32'h11223344);
        check("t4_mask", fp_mask, 4'b0011);
        i_bus_wr_valid = 1'b1;
        tick();
        check("t4_wrv", fp_wrv, 3'b001);
        check("t4_wr_drop", fp_wr, 0);
        m_wr_req = '0;
        i_bus_wr_valid = 1'b0;
        tick();
        check("t4_resp_noarb", fp_rd, 0);
        tick();
        check("t4_rd_follow", fp_rd, 1);
        check("t4_wr_off", fp_wr, 0);
        i_bus_rd_valid = 1'b1;
        i_bus_data     = 32'h5555AAAA;
        tick();
        check("t4_rdv", fp_rdv, 3'b001);
        check("t4_rdata", fp_rdata, 32'h5555AAAA);
        m_rd_req = '0;
        i_bus_rd_valid = 1'b0;
        tick();

        // timeout: slave stays silent
        m_rd_req = 3'b010;
        m_addr[32 +: 32] = 32'h104;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t5_rd_held", fp_rd, 1);
            check("t5_no_err", fp_err, 0);
        end
        tick();
        check("t5_rd_drop", fp_rd, 0);
        check("t5_err", fp_err, 3'b010);
        check("t5_no_rdv", fp_rdv, 0);
        check("t5_rdata0", fp_rdata, 0);
        check("t5_rr_err", rr_err, 3'b010);
        m_rd_req = '0;
        tick();
        check("t5_err_once", fp_err, 0);

        // wrong-type completion ignored, then reset mid-BUSY
        m_rd_req = 3'b100;
        m_addr[64 +: 32] = 32'h300;
        tick();
        check("t6_rd", fp_rd, 1);
        check("t6_addr", fp_addr, 32'h300);
        i_bus_wr_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("t6_ignore_rd", fp_rd, 1);
            check("t6_ignore_pulse", {fp_rdv, fp_wrv}, 0);
        end
        i_bus_wr_valid = 1'b0;
        m_rd_req = 3'b101;
        m_addr[0 +: 32] = 32'h40;
        rst = 1'b1;
        tick();
        check("t6_rst_rd", fp_rd, 0);
        check("t6_rst_addr", fp_addr, 0);
        check("t6_rst_pulse", {fp_rdv, fp_wrv, fp_err}, 0);
        check("t6_rst_rr_rd", rr_rd, 0);
        rst = 1'b0;
        tick();
        check("t6_fp_m0", fp_addr, 32'h40);
        check("t6_fp_rd", fp_rd, 1);
        check("t6_rr_m0", rr_addr, 32'h40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
